nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/cla_adder.sv | 27 ++
 rtl/nibble_serial_adder.sv | 110 +++++++++++
 tb/tb_nibble_serial_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;
  localparam int DATA_W  = 16;
  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead adder with fully expanded carry terms.
module cla_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign S    = w_p ^ w_c[3:0];
  assign cout = w_c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// 16-bit adder that processes one nibble per cycle through a single shared CLA.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              cin,
  output logic [DATA_W-1:0] S,
  output logic              cout,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam logic [1:0] LAST_NIB = 2'(NUM_NIB - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_s;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic [1:0]        r_cnt;
  logic [3:0]        w_base;
  logic [NIB_W-1:0]  w_a_nib;
  logic [NIB_W-1:0]  w_b_nib;
  logic [NIB_W-1:0]  w_sum;
  logic              w_nib_cout;

  assign w_base  = {r_cnt, 2'b00};
  assign w_a_nib = r_a[w_base +: NIB_W];
  assign w_b_nib = r_b[w_base +: NIB_W];

  cla_adder u_cla (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .cin  (r_carry),
    .S    (w_sum),
    .cout (w_nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ADD;
      end
      ADD: begin
        if (r_cnt == LAST_NIB) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Sum nibbles land in S as they are produced; out_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= 2'd0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= cin;
            r_cnt   <= 2'd0;
          end
        end
        ADD: begin
          r_s[w_base +: NIB_W] <= w_sum;
          r_carry              <= w_nib_cout;
          r_cnt                <= r_cnt + 2'd1;
          if (r_cnt == LAST_NIB) begin
            r_cout <= w_nib_cout;
            r_ovf  <= (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                      (w_sum[NIB_W-1] != r_a[DATA_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign S    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for the nibble-serial adder.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic [15:0] S;
  logic        cout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;
  logic        or_fixed;
  logic        or_rand;
  logic        rand_on;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [17:0] exp_q[$];

  assign out_ready = rand_on ? or_rand : or_fixed;

  nibble_serial_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: {cout,ovf,S} from plain 17-bit arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] sum;
    logic        v;
    sum = {1'b0, a} + {1'b0, b} + {16'd0, c};
    v   = (a[15] == b[15]) && (sum[15] != a[15]);
    return {sum[16], v, sum[15:0]};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tmo("unexpected_output");
      end else begin
        chk("result {cout,ovf,S}", {14'd0, cout, ovf, S}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    or_rand = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    bit done = 1'b0;
    A = a; B = b; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_q.push_back(model(a, b, c));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) tmo("send_accept");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() > 0) tmo(name);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic c);
    int lat;
    or_fixed = 1'b1;
    send(a, b, c);
    wait_valid(lat);
    chk("latency", lat, 4);
    @(posedge clk); #1;
    chk("drained", exp_q.size(), 0);
    chk("back_to_idle", {31'd0, in_ready}, 1);
  endtask

  initial begin
    int lat;
    int n;
    int seen;
    int acc[4];
    logic [17:0] hold;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0;
    or_fixed = 1'b0; rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 1);
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset {cout,ovf,S}", {14'd0, cout, ovf, S}, 0);
    rst = 1'b0;

    // Basic add, then a 10-cycle consumer stall.
    send(16'h1234, 16'h4321, 1'b0);
    wait_valid(lat);
    chk("latency_1234", lat, 4);
    hold = model(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall outputs", {14'd0, cout, ovf, S}, {14'd0, hold});
      chk("stall in_ready", {30'd0, in_ready, out_valid}, 1);
    end
    @(posedge clk); #1;
    or_fixed = 1'b1;
    @(posedge clk); #1;
    chk("release idle", {30'd0, in_ready, out_valid}, 2);
    chk("release drained", exp_q.size(), 0);

    run_one(16'hFFFF, 16'h0000, 1'b1);
    run_one(16'h7FFF, 16'h0001, 1'b0);
    run_one(16'h8000, 16'h8000, 1'b0);
    run_one(16'hFFFF, 16'hFFFF, 1'b1);

    // Abort while nibble 2 is being added.
    send(16'hABCD, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("abort in_ready/out_valid", {30'd0, in_ready, out_valid}, 2);
    chk("abort {cout,ovf,S}", {14'd0, cout, ovf, S}, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no output", seen, 0);
    @(posedge clk); #1;
    run_one(16'h0001, 16'h0001, 1'b0);

    // Streaming throughput with in_valid and out_ready held high.
    or_fixed = 1'b1;
    A = rnd16(); B = rnd16(); cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(A, B, cin));
        acc[n] = cyc;
        n++;
        @(posedge clk); #1;
        A = rnd16(); B = rnd16(); cin = 1'($urandom_range(0, 1));
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("throughput accepts", n, 4);
    for (int i = 0; i < 3; i++) chk("throughput spacing", acc[i+1] - acc[i], 6);
    drain("throughput_drain");

    // Random sweep with random consumer back-pressure.
    rand_on = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(rnd16(), rnd16(), 1'($urandom_range(0, 1)));
    end
    rand_on = 1'b0;
    or_fixed = 1'b1;
    drain("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
